// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants (1024x768@60, 65 MHz) and small helpers.
package vga_timing_gen_pkg;

    localparam int CNT_W = 11;
    localparam int RGB_W = 12;

    localparam int HOR_PIXELS     = 1024;
    localparam int HOR_TOTAL      = 1344;
    localparam int HOR_SYNC_START = 1048;
    localparam int HOR_SYNC_TIME  = 136;

    localparam int VER_PIXELS     = 768;
    localparam int VER_TOTAL      = 806;
    localparam int VER_SYNC_START = 771;
    localparam int VER_SYNC_TIME  = 6;

    typedef logic [CNT_W-1:0] cnt_t;

    // True when value lies in [start, start+len); widened to int so nothing truncates.
    function automatic logic in_window(cnt_t value, int start, int len);
        return (int'(value) >= start) && (int'(value) < start + len);
    endfunction

    // One axis is legal when the counter fits 11 bits and sync sits inside blanking.
    function automatic logic timing_legal(int total, int pixels, int sync_start, int sync_time);
        return (total >= 1) && (total <= 2047) && (pixels >= 0) && (pixels <= total) &&
               (sync_time >= 1) && (sync_start >= pixels) && (sync_start + sync_time <= total);
    endfunction

endpackage

// File: rtl/vga_if.sv
// Pixel-stream bundle passed along the draw chain.
interface vga_if;
    import vga_timing_gen_pkg::*;

    cnt_t             hcount;
    cnt_t             vcount;
    logic             hsync;
    logic             hblnk;
    logic             vsync;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;

    modport out (output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
endinterface

// File: rtl/vga_wrap_counter.sv
// 11-bit enabled counter that wraps to 0 after wrap_value; exposes its next value.
module vga_wrap_counter
    import vga_timing_gen_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  cnt_t wrap_value,
    output cnt_t count,
    output cnt_t count_next,
    output logic wrap
);

    // Next value and wrap pulse; the wrap only fires on an enabled advance.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wrap       = en && (count == wrap_value);
        count_next = count;
        if (en) begin
            count_next = wrap ? '0 : count + cnt_t'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) count <= '0;
        else     count <= count_next;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Source of the vga_if pixel stream: counters, sync/blank decode, frame/line strobes.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int HOR_PIXELS       = vga_timing_gen_pkg::HOR_PIXELS,
    parameter int HOR_TOTAL        = vga_timing_gen_pkg::HOR_TOTAL,
    parameter int HOR_SYNC_START   = vga_timing_gen_pkg::HOR_SYNC_START,
    parameter int HOR_SYNC_TIME    = vga_timing_gen_pkg::HOR_SYNC_TIME,
    parameter int VER_PIXELS       = vga_timing_gen_pkg::VER_PIXELS,
    parameter int VER_TOTAL        = vga_timing_gen_pkg::VER_TOTAL,
    parameter int VER_SYNC_START   = vga_timing_gen_pkg::VER_SYNC_START,
    parameter int VER_SYNC_TIME    = vga_timing_gen_pkg::VER_SYNC_TIME,
    parameter int SYNC_ACTIVE_HIGH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    vga_if.out          out,
    output logic        frame_start,
    output logic        line_start,
    output logic [15:0] frame_cnt
);

    if (!timing_legal(HOR_TOTAL, HOR_PIXELS, HOR_SYNC_START, HOR_SYNC_TIME) ||
        !timing_legal(VER_TOTAL, VER_PIXELS, VER_SYNC_START, VER_SYNC_TIME)) begin : gen_bad_params
        $error("vga_timing_gen: sync window must lie inside blanking and totals must be 1..2047");
    end

    localparam cnt_t H_LAST    = cnt_t'(HOR_TOTAL - 1);
    localparam cnt_t V_LAST    = cnt_t'(VER_TOTAL - 1);
    localparam cnt_t H_ACTIVE  = cnt_t'(HOR_PIXELS);
    localparam cnt_t V_ACTIVE  = cnt_t'(VER_PIXELS);
    localparam logic SYNC_ON   = (SYNC_ACTIVE_HIGH != 0);

    cnt_t h_count, h_next, v_count, v_next;
    logic h_wrap, v_wrap;
    logic hsync_next, hblnk_next, vsync_next, vblnk_next;
    logic hsync_q, hblnk_q, vsync_q, vblnk_q;

    vga_wrap_counter u_hcnt (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .wrap_value (H_LAST),
        .count      (h_count),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    // Vertical counter advances on the horizontal wrap; its wrap marks the end of a frame.
    vga_wrap_counter u_vcnt (
        .clk        (clk),
        .rst        (rst),
        .en         (h_wrap),
        .wrap_value (V_LAST),
        .count      (v_count),
        .count_next (v_next),
        .wrap       (v_wrap)
    );

    // Decode from the next counter values so registered fields line up with the counters.
    always_comb begin
        hblnk_next = (h_next >= H_ACTIVE);
        vblnk_next = (v_next >= V_ACTIVE);
        hsync_next = in_window(h_next, HOR_SYNC_START, HOR_SYNC_TIME) ? SYNC_ON : !SYNC_ON;
        vsync_next = in_window(v_next, VER_SYNC_START, VER_SYNC_TIME) ? SYNC_ON : !SYNC_ON;
    end

    // Output registers: hold while frozen, strobes only on an enabled advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            hblnk_q     <= 1'b0;
            vblnk_q     <= 1'b0;
            hsync_q     <= !SYNC_ON;
            vsync_q     <= !SYNC_ON;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else if (en) begin
            hblnk_q     <= hblnk_next;
            vblnk_q     <= vblnk_next;
            hsync_q     <= hsync_next;
            vsync_q     <= vsync_next;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            if (v_wrap) frame_cnt <= frame_cnt + 16'd1;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

    assign out.hcount = h_count;
    assign out.vcount = v_count;
    assign out.hsync  = hsync_q;
    assign out.hblnk  = hblnk_q;
    assign out.vsync  = vsync_q;
    assign out.vblnk  = vblnk_q;
    assign out.rgb    = '0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size line, reduced-size frames, freeze, reset, inverted syncs, frame_cnt wrap.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Full-size instance (default timing).
    logic rst_f, en_f, fs_f, ls_f;
    logic [15:0] fc_f;
    vga_if if_f ();
    vga_timing_gen u_full (
        .clk(clk), .rst(rst_f), .en(en_f), .out(if_f),
        .frame_start(fs_f), .line_start(ls_f), .frame_cnt(fc_f)
    );

    // Reduced instance: 16x8 total, active 10x5, hsync 11..13, vsync line 6.
    logic rst_s, en_s, fs_s, ls_s;
    logic [15:0] fc_s;
    vga_if if_s ();
    vga_timing_gen #(
        .HOR_PIXELS(10), .HOR_TOTAL(16), .HOR_SYNC_START(11), .HOR_SYNC_TIME(3),
        .VER_PIXELS(5),  .VER_TOTAL(8),  .VER_SYNC_START(6),  .VER_SYNC_TIME(1),
        .SYNC_ACTIVE_HIGH(1)
    ) u_small (
        .clk(clk), .rst(rst_s), .en(en_s), .out(if_s),
        .frame_start(fs_s), .line_start(ls_s), .frame_cnt(fc_s)
    );

    // Same reduced timing with active-low syncs.
    logic rst_i, en_i, fs_i, ls_i;
    logic [15:0] fc_i;
    vga_if if_i ();
    vga_timing_gen #(
        .HOR_PIXELS(10), .HOR_TOTAL(16), .HOR_SYNC_START(11), .HOR_SYNC_TIME(3),
        .VER_PIXELS(5),  .VER_TOTAL(8),  .VER_SYNC_START(6),  .VER_SYNC_TIME(1),
        .SYNC_ACTIVE_HIGH(0)
    ) u_inv (
        .clk(clk), .rst(rst_i), .en(en_i), .out(if_i),
        .frame_start(fs_i), .line_start(ls_i), .frame_cnt(fc_i)
    );

    // 1x1 frame: one frame per enabled cycle, used to exercise the frame_cnt wrap.
    logic rst_w, en_w, fs_w, ls_w;
    logic [15:0] fc_w;
    vga_if if_w ();
    vga_timing_gen #(
        .HOR_PIXELS(0), .HOR_TOTAL(1), .HOR_SYNC_START(0), .HOR_SYNC_TIME(1),
        .VER_PIXELS(0), .VER_TOTAL(1), .VER_SYNC_START(0), .VER_SYNC_TIME(1),
        .SYNC_ACTIVE_HIGH(1)
    ) u_wrap (
        .clk(clk), .rst(rst_w), .en(en_w), .out(if_w),
        .frame_start(fs_w), .line_start(ls_w), .frame_cnt(fc_w)
    );

    int w_edges = 0;
    always @(posedge clk) if (!rst_w && en_w) w_edges <= w_edges + 1;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_small(input int eh, input int ev, input int efc, input logic els, input logic efs);
        check("s_hcount", 32'(if_s.hcount), eh);
        check("s_vcount", 32'(if_s.vcount), ev);
        check("s_hblnk",  32'(if_s.hblnk),  (eh >= 10) ? 1 : 0);
        check("s_hsync",  32'(if_s.hsync),  (eh >= 11 && eh <= 13) ? 1 : 0);
        check("s_vblnk",  32'(if_s.vblnk),  (ev >= 5) ? 1 : 0);
        check("s_vsync",  32'(if_s.vsync),  (ev == 6) ? 1 : 0);
        check("s_line_start",  32'(ls_s), 32'(els));
        check("s_frame_start", 32'(fs_s), 32'(efs));
        check("s_frame_cnt",   32'(fc_s), efc);
    endtask

    initial begin
        int hs_cnt;
        int eh, ev;

        rst_f = 1'b1; rst_s = 1'b1; rst_i = 1'b1; rst_w = 1'b1;
        en_f  = 1'b0; en_s  = 1'b0; en_i  = 1'b0; en_w  = 1'b1;
        repeat (5) tick();

        // Reset state.
        check("rst_hcount", 32'(if_f.hcount), 0);
        check("rst_vcount", 32'(if_f.vcount), 0);
        check("rst_hsync",  32'(if_f.hsync),  0);
        check("rst_vsync",  32'(if_f.vsync),  0);
        check("rst_hblnk",  32'(if_f.hblnk),  0);
        check("rst_vblnk",  32'(if_f.vblnk),  0);
        check("rst_rgb",    32'(if_f.rgb),    0);
        check("rst_strobes", {30'd0, fs_f, ls_f}, 0);
        check("rst_frame_cnt", 32'(fc_f), 0);
        check("rst_inv_hsync", 32'(if_i.hsync), 1);
        check("rst_inv_vsync", 32'(if_i.vsync), 1);
        check("rst_wrap_cnt",  32'(fc_w), 0);

        rst_f = 1'b0; rst_s = 1'b0; rst_i = 1'b0; rst_w = 1'b0;
        en_f  = 1'b1;

        // One full-size line: 1344 enabled cycles back to hcount 0 on line 1.
        hs_cnt = 0;
        for (int i = 1; i <= 1344; i++) begin
            tick();
            eh = i % 1344;
            ev = (i == 1344) ? 1 : 0;
            hs_cnt += int'(if_f.hsync);
            check("f_hcount", 32'(if_f.hcount), eh);
            check("f_vcount", 32'(if_f.vcount), ev);
            check("f_hblnk",  32'(if_f.hblnk),  (eh >= 1024) ? 1 : 0);
            check("f_hsync",  32'(if_f.hsync),  (eh >= 1048 && eh <= 1183) ? 1 : 0);
            check("f_vblnk",  32'(if_f.vblnk),  0);
            check("f_line_start",  32'(ls_f), (eh == 0) ? 1 : 0);
            check("f_frame_start", 32'(fs_f), 0);
        end
        check("f_hsync_width", hs_cnt, 136);
        en_f = 1'b0;

        // Reduced timing was out of reset but frozen: reset values, no strobes.
        check_small(0, 0, 0, 1'b0, 1'b0);

        // One reduced frame (128 cycles) on both polarities.
        en_s = 1'b1; en_i = 1'b1;
        for (int k = 1; k <= 128; k++) begin
            tick();
            eh = k % 16;
            ev = (k / 16) % 8;
            check_small(eh, ev, k / 128, eh == 0, (eh == 0) && (ev == 0));
            check("i_hsync", 32'(if_i.hsync), (eh >= 11 && eh <= 13) ? 0 : 1);
            check("i_vsync", 32'(if_i.vsync), (ev == 6) ? 0 : 1);
            check("i_hblnk", 32'(if_i.hblnk), (eh >= 10) ? 1 : 0);
        end
        en_i = 1'b0;

        // Run to the last pixel of the frame, then freeze for 10 cycles.
        repeat (127) tick();
        check_small(15, 7, 1, 1'b0, 1'b0);
        en_s = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_small(15, 7, 1, 1'b0, 1'b0);
        end

        // Re-enable: wrap to (0,0) with both strobes, then freeze with strobes forced low.
        en_s = 1'b1;
        tick();
        check_small(0, 0, 2, 1'b1, 1'b1);
        en_s = 1'b0;
        tick();
        check_small(0, 0, 2, 1'b0, 1'b0);
        tick();
        check_small(0, 0, 2, 1'b0, 1'b0);

        // Mid-frame reset at (12,6) where both syncs and blanks are active.
        en_s = 1'b1;
        repeat (108) tick();
        check_small(12, 6, 2, 1'b0, 1'b0);
        rst_s = 1'b1;
        tick();
        check_small(0, 0, 0, 1'b0, 1'b0);
        rst_s = 1'b0;
        tick();
        check_small(1, 0, 0, 1'b0, 1'b0);

        // frame_cnt wrap on the 1x1 instance: 65535 -> 0 -> 1.
        while (w_edges < 65535) tick();
        check("w_frame_cnt_max",  32'(fc_w), 65535);
        check("w_frame_start_a",  32'(fs_w), 1);
        tick();
        check("w_frame_cnt_wrap", 32'(fc_w), 0);
        check("w_frame_start_b",  32'(fs_w), 1);
        check("w_hcount",         32'(if_w.hcount), 0);
        tick();
        check("w_frame_cnt_next", 32'(fc_w), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
